// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the single-port node memory.
// One master owns the memory at a time (registered one-hot grant). While a
// master is granted and requesting, its address, write enable and write data
// are muxed onto the memory port. A lock keeps ownership across cycles, up to
// MAX_HOLD consecutive accesses. Read results are routed back to the issuing
// master by a tag that travels RD_LAT cycles alongside the memory read.
module mem_port_arbiter #(
  parameter int NREQ     = 3,
  parameter int AW       = 11,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 64
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ-1:0]   wr_en_in,
  input  logic [NREQ*AW-1:0] addr_in,
  input  logic [NREQ*DW-1:0] wdata_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic              hold_err,
  output logic [AW-1:0]     mem_address,
  output logic              mem_wr_en,
  output logic [DW-1:0]     mem_data_in,
  input  logic [DW-1:0]     mem_data_out
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   w_owner_nx;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   w_last_nx;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] w_gnt_nx;
  logic [HW-1:0]   r_hold_cnt;
  logic [HW-1:0]   w_hold_cnt_nx;

  logic [AW-1:0]   r_addr_hold;
  logic [DW-1:0]   r_wdata_hold;

  // Read-return tag pipeline: stage p0 is the tag of the read issued in the
  // previous cycle, the last stage lines up with mem_data_out.
  logic [NREQ-1:0] r_rtag_p [RD_LAT];
  logic [NREQ-1:0] w_rtag;

  logic            w_access;
  logic            w_hold_hit;
  logic            w_release;
  logic            w_any_req;
  logic [IW-1:0]   w_pick;
  logic [AW-1:0]   w_addr_o;
  logic [DW-1:0]   w_wdata_o;
  logic            w_wr_o;
  logic            w_req_o;
  logic            w_lock_o;

  // First requester strictly after 'after' in cyclic order; 'after' itself is
  // visited last, so it only wins when it is the sole requester.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   after);
    logic [IW-1:0] pick;
    int            idx;
    pick = after;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(after) + k) % NREQ;
      if (r[IW'(idx)]) pick = IW'(idx);
    end
    return pick;
  endfunction

  // Select the current owner's request, lock and transaction fields
  always_comb begin
    w_req_o   = req[r_owner];
    w_lock_o  = lock[r_owner];
    w_wr_o    = wr_en_in[r_owner];
    w_addr_o  = addr_in[int'(r_owner)*AW +: AW];
    w_wdata_o = wdata_in[int'(r_owner)*DW +: DW];
  end

  // Access qualification, forced-release detection and next grant selection
  always_comb begin
    w_any_req  = |req;
    w_access   = (r_state == S_OWN) && w_req_o;
    w_hold_hit = w_access && w_lock_o && (r_hold_cnt == HW'(MAX_HOLD - 1));
    w_release  = (r_state == S_OWN) && (!w_req_o || !w_lock_o || w_hold_hit);
    w_pick     = rr_pick(req, (r_state == S_OWN) ? r_owner : r_last);
    w_rtag     = (w_access && !w_wr_o) ? r_gnt : '0;
  end

  // Next-state logic for ownership, grant, RR pointer and hold counter
  always_comb begin
    w_state_nx    = r_state;
    w_owner_nx    = r_owner;
    w_last_nx     = r_last;
    w_gnt_nx      = r_gnt;
    w_hold_cnt_nx = r_hold_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nx    = S_OWN;
          w_owner_nx    = w_pick;
          w_gnt_nx      = NREQ'(1) << w_pick;
          w_hold_cnt_nx = '0;
        end
      end
      S_OWN: begin
        if (w_release) begin
          w_last_nx     = r_owner;
          w_hold_cnt_nx = '0;
          if (w_any_req) begin
            w_owner_nx = w_pick;
            w_gnt_nx   = NREQ'(1) << w_pick;
          end else begin
            w_state_nx = S_IDLE;
            w_gnt_nx   = '0;
          end
        end else if (w_access) begin
          w_hold_cnt_nx = r_hold_cnt + HW'(1);
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_gnt_nx   = '0;
      end
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_last     <= IW'(NREQ - 1);
      r_gnt      <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_owner    <= w_owner_nx;
      r_last     <= w_last_nx;
      r_gnt      <= w_gnt_nx;
      r_hold_cnt <= w_hold_cnt_nx;
    end
  end

  // Remember the last driven address/data so the port holds them when idle
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else if (w_access) begin
      r_addr_hold  <= w_addr_o;
      r_wdata_hold <= w_wdata_o;
    end
  end

  // Read tag pipeline, aligned with the memory read latency
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) r_rtag_p[k] <= '0;
    end else begin
      r_rtag_p[0] <= w_rtag;
      for (int k = 1; k < RD_LAT; k++) r_rtag_p[k] <= r_rtag_p[k-1];
    end
  end

  // Memory port and master-facing outputs
  always_comb begin
    mem_wr_en   = w_access && w_wr_o;
    mem_address = w_access ? w_addr_o  : r_addr_hold;
    mem_data_in = w_access ? w_wdata_o : r_wdata_hold;
    gnt         = r_gnt;
    rvalid      = r_rtag_p[RD_LAT-1];
    rdata       = mem_data_out;
    hold_err    = w_hold_hit;
  end

endmodule
